// File: rtl/round_sequencer.sv
// round_sequencer: game round controller.
// Sequences each round through pattern generation, pattern display and player
// input via req/done handshakes, then scores the round, waits an optional
// gap and starts the next round until NUM_ROUNDS rounds have been played.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous active-low reset
//   start        one-cycle pulse, begins a game with the sampled level
//   abort        synchronous abort back to IDLE
//   level        one-hot level select (001 = L1, 010 = L2, 100 = L3)
//   gen_req      pattern-generate request   / gen_done  completion
//   show_req     pattern-display request    / show_done completion
//   inp_req      player-input request       / inp_done  completion
//   match        round-win flag, valid with inp_done
//   seq_len      pattern length of the latched level
//   level_q      latched level
//   round_count  completed rounds
//   score        won rounds
//   busy         game in progress (not IDLE/DONE)
//   game_over    game finished, held until start or abort
//   timeout_flag sticky: some round of this game timed out
//   level_err    one-cycle pulse: start with a non-one-hot level
module round_sequencer #(
   parameter int unsigned NUM_ROUNDS     = 10,
   parameter int unsigned LEN_L1         = 4,
   parameter int unsigned LEN_L2         = 8,
   parameter int unsigned LEN_L3         = 16,
   parameter int unsigned MAX_LEN        = 16,
   parameter int unsigned GAP_CYCLES     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 0,
   localparam int unsigned LW = $clog2(MAX_LEN + 1),
   localparam int unsigned RW = $clog2(NUM_ROUNDS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [2:0]    level,
   output logic          gen_req,
   input  logic          gen_done,
   output logic          show_req,
   input  logic          show_done,
   output logic          inp_req,
   input  logic          inp_done,
   input  logic          match,
   output logic [LW-1:0] seq_len,
   output logic [2:0]    level_q,
   output logic [RW-1:0] round_count,
   output logic [RW-1:0] score,
   output logic          busy,
   output logic          game_over,
   output logic          timeout_flag,
   output logic          level_err
);

   // Counters only need to reach LIMIT-1; keep at least one bit when disabled.
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GEN,
      S_SHOW,
      S_INPUT,
      S_SCORE,
      S_GAP,
      S_DONE
   } state_t;

   state_t          state_q, state_n;
   logic            win_q, win_n;
   logic [TW-1:0]   tcnt_q, tcnt_n;
   logic [GW-1:0]   gcnt_q, gcnt_n;
   logic [RW-1:0]   round_n, score_n;
   logic [2:0]      level_n;
   logic [LW-1:0]   len_n;
   logic            tflag_n;
   logic            lerr_n;

   // Pattern length of a one-hot level.
   function automatic logic [LW-1:0] level_len(input logic [2:0] lv);
      case (lv)
         3'b001:  level_len = LW'(LEN_L1);
         3'b010:  level_len = LW'(LEN_L2);
         3'b100:  level_len = LW'(LEN_L3);
         default: level_len = '0;
      endcase
   endfunction

   // State and registered outputs; outputs are decoded from the next state so
   // each req is high exactly while its state is active.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         win_q        <= 1'b0;
         tcnt_q       <= '0;
         gcnt_q       <= '0;
         round_count  <= '0;
         score        <= '0;
         level_q      <= 3'b000;
         seq_len      <= '0;
         timeout_flag <= 1'b0;
         level_err    <= 1'b0;
         gen_req      <= 1'b0;
         show_req     <= 1'b0;
         inp_req      <= 1'b0;
         busy         <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         state_q      <= state_n;
         win_q        <= win_n;
         tcnt_q       <= tcnt_n;
         gcnt_q       <= gcnt_n;
         round_count  <= round_n;
         score        <= score_n;
         level_q      <= level_n;
         seq_len      <= len_n;
         timeout_flag <= tflag_n;
         level_err    <= lerr_n;
         gen_req      <= (state_n == S_GEN);
         show_req     <= (state_n == S_SHOW);
         inp_req      <= (state_n == S_INPUT);
         busy         <= (state_n != S_IDLE) && (state_n != S_DONE);
         game_over    <= (state_n == S_DONE);
      end
   end

   // Next-state and next-value logic; abort beats start and every done.
   always_comb begin
      state_n = state_q;
      win_n   = win_q;
      tcnt_n  = tcnt_q;
      gcnt_n  = gcnt_q;
      round_n = round_count;
      score_n = score;
      level_n = level_q;
      len_n   = seq_len;
      tflag_n = timeout_flag;
      lerr_n  = 1'b0;

      if (abort) begin
         state_n = S_IDLE;
         win_n   = 1'b0;
         tcnt_n  = '0;
         gcnt_n  = '0;
         round_n = '0;
         score_n = '0;
         level_n = 3'b000;
         len_n   = '0;
         tflag_n = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  if ($onehot(level)) begin
                     level_n = level;
                     len_n   = level_len(level);
                     round_n = '0;
                     score_n = '0;
                     tflag_n = 1'b0;
                     state_n = S_GEN;
                  end else begin
                     lerr_n = 1'b1;
                  end
               end
            end
            S_GEN: begin
               if (gen_done) state_n = S_SHOW;
            end
            S_SHOW: begin
               if (show_done) begin
                  tcnt_n  = '0;
                  state_n = S_INPUT;
               end
            end
            S_INPUT: begin
               // inp_done takes precedence over a same-cycle expiry
               if (inp_done) begin
                  win_n   = match;
                  state_n = S_SCORE;
               end else if ((TIMEOUT_CYCLES > 0) && (tcnt_q == TW'(TIMEOUT_CYCLES - 1))) begin
                  win_n   = 1'b0;
                  tflag_n = 1'b1;
                  state_n = S_SCORE;
               end else if (TIMEOUT_CYCLES > 0) begin
                  tcnt_n = tcnt_q + TW'(1);
               end
            end
            S_SCORE: begin
               round_n = round_count + RW'(1);
               score_n = score + RW'(win_q);
               if (round_count == RW'(NUM_ROUNDS - 1)) begin
                  state_n = S_DONE;
               end else if (GAP_CYCLES > 0) begin
                  gcnt_n  = '0;
                  state_n = S_GAP;
               end else begin
                  state_n = S_GEN;
               end
            end
            S_GAP: begin
               if (gcnt_q == GW'(GAP_CYCLES - 1)) begin
                  state_n = S_GEN;
               end else begin
                  gcnt_n = gcnt_q + GW'(1);
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer. Two instances share clk/rst:
// dut 0 uses the default parameters, dut 1 uses NUM_ROUNDS=3 and
// TIMEOUT_CYCLES=20. Inputs change 1 time unit after posedge and outputs are
// sampled at the same point, so each tick() shows the result of one edge.
module tb_round_sequencer;

   localparam int unsigned LW = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          start_s     [2];
   logic          abort_s     [2];
   logic [2:0]    level_s     [2];
   logic          gen_done_s  [2];
   logic          show_done_s [2];
   logic          inp_done_s  [2];
   logic          match_s     [2];
   logic          gen_req_s   [2];
   logic          show_req_s  [2];
   logic          inp_req_s   [2];
   logic [LW-1:0] seq_len_s   [2];
   logic [2:0]    level_q_s   [2];
   logic          busy_s      [2];
   logic          game_over_s [2];
   logic          tflag_s     [2];
   logic          lerr_s      [2];
   logic [3:0]    rc_a, sc_a;
   logic [1:0]    rc_b, sc_b;

   int errors = 0;
   int checks = 0;

   round_sequencer u_a (
      .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]), .level(level_s[0]),
      .gen_req(gen_req_s[0]), .gen_done(gen_done_s[0]),
      .show_req(show_req_s[0]), .show_done(show_done_s[0]),
      .inp_req(inp_req_s[0]), .inp_done(inp_done_s[0]), .match(match_s[0]),
      .seq_len(seq_len_s[0]), .level_q(level_q_s[0]),
      .round_count(rc_a), .score(sc_a),
      .busy(busy_s[0]), .game_over(game_over_s[0]),
      .timeout_flag(tflag_s[0]), .level_err(lerr_s[0])
   );

   round_sequencer #(.NUM_ROUNDS(3), .TIMEOUT_CYCLES(20)) u_b (
      .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]), .level(level_s[1]),
      .gen_req(gen_req_s[1]), .gen_done(gen_done_s[1]),
      .show_req(show_req_s[1]), .show_done(show_done_s[1]),
      .inp_req(inp_req_s[1]), .inp_done(inp_done_s[1]), .match(match_s[1]),
      .seq_len(seq_len_s[1]), .level_q(level_q_s[1]),
      .round_count(rc_b), .score(sc_b),
      .busy(busy_s[1]), .game_over(game_over_s[1]),
      .timeout_flag(tflag_s[1]), .level_err(lerr_s[1])
   );

   function automatic logic [3:0] rc(input int d);
      return (d == 0) ? rc_a : {2'b00, rc_b};
   endfunction

   function automatic logic [3:0] sc(input int d);
      return (d == 0) ? sc_a : {2'b00, sc_b};
   endfunction

   function automatic logic req(input int d, input int ph);
      case (ph)
         0:       return gen_req_s[d];
         1:       return show_req_s[d];
         default: return inp_req_s[d];
      endcase
   endfunction

   function automatic logic [2:0] reqs(input int d);
      return {gen_req_s[d], show_req_s[d], inp_req_s[d]};
   endfunction

   // Every output packed together; all zero means reset values.
   function automatic logic [22:0] outs(input int d);
      return {gen_req_s[d], show_req_s[d], inp_req_s[d], busy_s[d], game_over_s[d],
              tflag_s[d], lerr_s[d], level_q_s[d], seq_len_s[d], rc(d), sc(d)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input int d, input logic [2:0] lv);
      level_s[d] = lv;
      start_s[d] = 1'b1;
      tick();
      start_s[d] = 1'b0;
   endtask

   task automatic wait_req(input int d, input int ph);
      int n = 0;
      while (!req(d, ph) && n < 60) begin
         tick();
         n++;
      end
      checks++;
      if (req(d, ph) !== 1'b1) begin
         errors++;
         $display("FAIL wait_req dut=%0d phase=%0d: req=%b after %0d cycles, required 1",
                  d, ph, req(d, ph), n);
      end
   endtask

   // Answer a request with its done, sampled on the third req-high cycle.
   task automatic handshake(input int d, input int ph, input logic m);
      wait_req(d, ph);
      tick();
      tick();
      case (ph)
         0:       gen_done_s[d]  = 1'b1;
         1:       show_done_s[d] = 1'b1;
         default: begin inp_done_s[d] = 1'b1; match_s[d] = m; end
      endcase
      tick();
      gen_done_s[d]  = 1'b0;
      show_done_s[d] = 1'b0;
      inp_done_s[d]  = 1'b0;
      match_s[d]     = 1'b0;
   endtask

   // One full round; returns with SCORE as the current state.
   task automatic play_round(input int d, input logic m);
      handshake(d, 0, 1'b0);
      handshake(d, 1, 1'b0);
      handshake(d, 2, m);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (outs(d) !== 23'd0) begin
            errors++;
            $display("FAIL reset_outs dut=%0d: got %h, required 0", d, outs(d));
         end
      end
      rst = 1'b1;
      tick();
      checks++;
      if (outs(0) !== 23'd0) begin
         errors++;
         $display("FAIL reset_release: got %h, required 0", outs(0));
      end
   endtask

   task automatic test_level_err();
      logic [2:0] bad [2];
      bad[0] = 3'b011;
      bad[1] = 3'b000;
      for (int i = 0; i < 2; i++) begin
         pulse_start(0, bad[i]);
         checks++;
         if (lerr_s[0] !== 1'b1) begin
            errors++;
            $display("FAIL level_err_pulse lv=%b: got %b, required 1", bad[i], lerr_s[0]);
         end
         checks++;
         if ({busy_s[0], reqs(0)} !== 4'b0000) begin
            errors++;
            $display("FAIL level_err_idle lv=%b: busy/reqs=%b, required 0000", bad[i], {busy_s[0], reqs(0)});
         end
         tick();
         checks++;
         if (lerr_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL level_err_width lv=%b: got %b, required 0", bad[i], lerr_s[0]);
         end
      end
   endtask

   task automatic test_defaults();
      level_s[0] = 3'b010;
      start_s[0] = 1'b1;
      checks++;
      if (gen_req_s[0] !== 1'b0) begin
         errors++;
         $display("FAIL gen_req_early: got %b, required 0", gen_req_s[0]);
      end
      tick();
      start_s[0] = 1'b0;
      checks++;
      if (gen_req_s[0] !== 1'b1) begin
         errors++;
         $display("FAIL gen_req_rise: got %b, required 1", gen_req_s[0]);
      end
      checks++;
      if ({seq_len_s[0], level_q_s[0], busy_s[0], game_over_s[0]} !== {5'd8, 3'b010, 2'b10}) begin
         errors++;
         $display("FAIL start_latch: seq_len=%0d level_q=%b busy=%b game_over=%b, required 8 010 1 0",
                  seq_len_s[0], level_q_s[0], busy_s[0], game_over_s[0]);
      end
      for (int r = 0; r < 10; r++) play_round(0, 1'b1);
      tick();
      checks++;
      if ({game_over_s[0], busy_s[0], rc(0), sc(0)} !== {2'b10, 4'd10, 4'd10}) begin
         errors++;
         $display("FAIL default_game_end: game_over=%b busy=%b rounds=%0d score=%0d, required 1 0 10 10",
                  game_over_s[0], busy_s[0], rc(0), sc(0));
      end
      tick();
      checks++;
      if ({game_over_s[0], rc(0), sc(0), seq_len_s[0]} !== {1'b1, 4'd10, 4'd10, 5'd8}) begin
         errors++;
         $display("FAIL done_hold: game_over=%b rounds=%0d score=%0d seq_len=%0d, required 1 10 10 8",
                  game_over_s[0], rc(0), sc(0), seq_len_s[0]);
      end
   endtask

   task automatic test_ignored_done();
      pulse_start(0, 3'b010);
      show_done_s[0] = 1'b1;
      inp_done_s[0]  = 1'b1;
      match_s[0]     = 1'b1;
      tick();
      show_done_s[0] = 1'b0;
      inp_done_s[0]  = 1'b0;
      match_s[0]     = 1'b0;
      tick();
      checks++;
      if (reqs(0) !== 3'b100) begin
         errors++;
         $display("FAIL stray_done_in_gen: reqs=%b, required 100", reqs(0));
      end
      handshake(0, 0, 1'b0);
      checks++;
      if ({reqs(0), rc(0)} !== {3'b010, 4'd0}) begin
         errors++;
         $display("FAIL gen_done_advance: reqs=%b rounds=%0d, required 010 0", reqs(0), rc(0));
      end
      abort_s[0] = 1'b1;
      tick();
      abort_s[0] = 1'b0;
      checks++;
      if (outs(0) !== 23'd0) begin
         errors++;
         $display("FAIL abort_in_show: got %h, required 0", outs(0));
      end
   endtask

   task automatic test_abort_reset();
      pulse_start(0, 3'b010);
      for (int r = 0; r < 4; r++) play_round(0, 1'b1);
      handshake(0, 0, 1'b0);
      wait_req(0, 1);
      checks++;
      if ({rc(0), sc(0)} !== {4'd4, 4'd4}) begin
         errors++;
         $display("FAIL round5_counts: rounds=%0d score=%0d, required 4 4", rc(0), sc(0));
      end
      tick();
      abort_s[0] = 1'b1;
      start_s[0] = 1'b1;
      level_s[0] = 3'b001;
      tick();
      abort_s[0] = 1'b0;
      start_s[0] = 1'b0;
      checks++;
      if (outs(0) !== 23'd0) begin
         errors++;
         $display("FAIL abort_outs: got %h, required 0", outs(0));
      end
      tick();
      tick();
      checks++;
      if (outs(0) !== 23'd0) begin
         errors++;
         $display("FAIL abort_start_ignored: got %h, required 0", outs(0));
      end
      pulse_start(0, 3'b100);
      handshake(0, 0, 1'b0);
      handshake(0, 1, 1'b0);
      wait_req(0, 2);
      rst = 1'b0;
      inp_done_s[0] = 1'b1;
      match_s[0]    = 1'b1;
      tick();
      checks++;
      if (outs(0) !== 23'd0) begin
         errors++;
         $display("FAIL reset_in_input: got %h, required 0", outs(0));
      end
      rst = 1'b1;
      inp_done_s[0] = 1'b0;
      match_s[0]    = 1'b0;
      tick();
      checks++;
      if (outs(0) !== 23'd0) begin
         errors++;
         $display("FAIL reset_discards_game: got %h, required 0", outs(0));
      end
   endtask

   task automatic test_gap_pattern();
      logic m [3];
      int   n;
      m[0] = 1'b1;
      m[1] = 1'b0;
      m[2] = 1'b1;
      pulse_start(1, 3'b001);
      checks++;
      if (seq_len_s[1] !== 5'd4) begin
         errors++;
         $display("FAIL seq_len_l1: got %0d, required 4", seq_len_s[1]);
      end
      for (int r = 0; r < 3; r++) begin
         play_round(1, m[r]);
         if (r < 2) begin
            tick();
            checks++;
            if (rc(1) !== 4'(r + 1)) begin
               errors++;
               $display("FAIL gap_round_count r=%0d: got %0d, required %0d", r, rc(1), r + 1);
            end
            // GAP length from its first cycle to gen_req rising
            n = 0;
            while (reqs(1) == 3'b000 && n < 20) begin
               n++;
               tick();
            end
            checks++;
            if (n !== 4 || gen_req_s[1] !== 1'b1) begin
               errors++;
               $display("FAIL gap_length r=%0d: got %0d cycles gen_req=%b, required 4 cycles then 1",
                        r, n, gen_req_s[1]);
            end
         end
      end
      tick();
      checks++;
      if ({game_over_s[1], rc(1), sc(1)} !== {1'b1, 4'd3, 4'd2}) begin
         errors++;
         $display("FAIL pattern_101_end: game_over=%b rounds=%0d score=%0d, required 1 3 2",
                  game_over_s[1], rc(1), sc(1));
      end
   endtask

   task automatic test_timeout();
      int n;
      pulse_start(1, 3'b100);
      checks++;
      if (seq_len_s[1] !== 5'd16) begin
         errors++;
         $display("FAIL seq_len_l3: got %0d, required 16", seq_len_s[1]);
      end
      handshake(1, 0, 1'b0);
      handshake(1, 1, 1'b0);
      n = 0;
      while (inp_req_s[1] && n < 40) begin
         n++;
         tick();
      end
      checks++;
      if (n !== 20 || tflag_s[1] !== 1'b1) begin
         errors++;
         $display("FAIL timeout_expiry: inp_req cycles=%0d flag=%b, required 20 1", n, tflag_s[1]);
      end
      tick();
      checks++;
      if ({rc(1), sc(1)} !== {4'd1, 4'd0}) begin
         errors++;
         $display("FAIL timeout_score: rounds=%0d score=%0d, required 1 0", rc(1), sc(1));
      end
      // Second round: inp_done on the 20th input cycle wins over expiry
      handshake(1, 0, 1'b0);
      handshake(1, 1, 1'b0);
      repeat (19) tick();
      checks++;
      if (inp_req_s[1] !== 1'b1) begin
         errors++;
         $display("FAIL inp_req_cycle20: got %b, required 1", inp_req_s[1]);
      end
      inp_done_s[1] = 1'b1;
      match_s[1]    = 1'b1;
      tick();
      inp_done_s[1] = 1'b0;
      match_s[1]    = 1'b0;
      tick();
      checks++;
      if ({rc(1), sc(1), tflag_s[1]} !== {4'd2, 4'd1, 1'b1}) begin
         errors++;
         $display("FAIL done_beats_timeout: rounds=%0d score=%0d flag=%b, required 2 1 1",
                  rc(1), sc(1), tflag_s[1]);
      end
      play_round(1, 1'b0);
      tick();
      checks++;
      if ({game_over_s[1], tflag_s[1], rc(1), sc(1)} !== {2'b11, 4'd3, 4'd1}) begin
         errors++;
         $display("FAIL timeout_game_end: game_over=%b flag=%b rounds=%0d score=%0d, required 1 1 3 1",
                  game_over_s[1], tflag_s[1], rc(1), sc(1));
      end
      pulse_start(1, 3'b001);
      checks++;
      if ({tflag_s[1], rc(1), game_over_s[1], gen_req_s[1]} !== {1'b0, 4'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL restart_clears: flag=%b rounds=%0d game_over=%b gen_req=%b, required 0 0 0 1",
                  tflag_s[1], rc(1), game_over_s[1], gen_req_s[1]);
      end
      abort_s[1] = 1'b1;
      tick();
      abort_s[1] = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         start_s[d]     = 1'b0;
         abort_s[d]     = 1'b0;
         level_s[d]     = 3'b000;
         gen_done_s[d]  = 1'b0;
         show_done_s[d] = 1'b0;
         inp_done_s[d]  = 1'b0;
         match_s[d]     = 1'b0;
      end
      test_reset();
      test_level_err();
      test_defaults();
      test_ignored_done();
      test_abort_reset();
      test_gap_pattern();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
Parameters (name, default, meaning):
REQ-001 NUM_ROUNDS, 10, rounds per game; legal range 1..255.
REQ-002 LEN_L1 / LEN_L2 / LEN_L3, 4 / 8 / 16, pattern length for level 1/2/3; each in 1..MAX_LEN.
REQ-003 MAX_LEN, 16, maximum pattern length; sets LW = $clog2(MAX_LEN+1).
REQ-004 GAP_CYCLES, 4, idle clk cycles between rounds; 0 means no gap state.
REQ-005 TIMEOUT_CYCLES, 0, max INPUT-state cycles; 0 disables the timeout.
REQ-006 RW = $clog2(NUM_ROUNDS+1), derived width of round and score counters.
Ports (name, direction, width, meaning):
REQ-007 clk  in  1  single system clock; all logic on posedge.
REQ-008 rst  in  1  synchronous active-low reset, sampled on posedge clk.
REQ-009 start  in  1  one-cycle pulse, begin game with the sampled level.
REQ-010 abort  in  1  synchronous abort, return to IDLE.
REQ-011 level  in  3  one-hot level select: 001 = L1, 010 = L2, 100 = L3.
REQ-012 gen_req / gen_done  out / in  1 / 1  pattern-generate handshake.
REQ-013 show_req / show_done  out / in  1 / 1  pattern-display handshake.
REQ-014 inp_req / inp_done  out / in  1 / 1  player-input handshake.
REQ-015 match  in  1  round-win flag from the comparator, valid in the inp_done cycle.
REQ-016 seq_len  out  LW  pattern length of the latched level.
REQ-017 level_q  out  3  latched level.
REQ-018 round_count / score  out  RW / RW  completed rounds and won rounds.
REQ-019 busy / game_over / timeout_flag / level_err  out  1 each  status outputs.

Function
REQ-020 States: IDLE, GEN, SHOW, INPUT, SCORE, GAP, DONE; all transitions occur on posedge clk.
REQ-021 IDLE/DONE with start=1 and level one-hot: latch level_q, load seq_len from LEN_Lx, clear round_count, score and timeout_flag, then go to GEN.
REQ-022 IDLE/DONE with start=1 and level not one-hot: pulse level_err high for 1 cycle and leave the state unchanged; start is ignored in every other state.
REQ-023 Each xxx_req is high in every cycle its state is active and low otherwise, so it drops the cycle after xxx_done is accepted.
REQ-024 Done handling per state:
- GEN: gen_done=1 goes to SHOW.
- SHOW: show_done=1 goes to INPUT.
- INPUT: inp_done=1 captures match and goes to SCORE.
- A done input received outside its own state is ignored.
REQ-025 INPUT timeout counter:
- Clears on entry to INPUT.
- If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 without inp_done: capture win=0, set timeout_flag, go to SCORE.
- If inp_done and expiry occur in the same cycle, inp_done wins.
REQ-026 SCORE lasts exactly 1 cycle: round_count += 1, score += captured win.
- If round_count+1 == NUM_ROUNDS, go to DONE.
- Otherwise, go to GAP if GAP_CYCLES>0, else to GEN.
REQ-027 GAP lasts exactly GAP_CYCLES cycles, then goes to GEN.
REQ-028 DONE: game_over=1, held until start or abort; round_count and score hold their values.
REQ-029 busy=1 in every state except IDLE and DONE.
REQ-030 Counters never wrap: score <= round_count <= NUM_ROUNDS always.
REQ-031 abort=1 in any state forces IDLE next cycle with all outputs at reset values; abort has priority over start and over every done input.
REQ-032 timeout_flag is sticky for the rest of the game (set by any timed-out round) and clears on the next accepted start.

Reset
REQ-033 rst=0 at posedge clk forces state IDLE and clears all counters.
REQ-034 Output values while in reset:
- All reqs = 0.
- level_q = 000, seq_len = 0.
- round_count = 0, score = 0.
- busy = 0, game_over = 0, timeout_flag = 0, level_err = 0.
REQ-035 Reset overrides abort, start and every done input; reset mid-game discards the game in progress.

Verification
REQ-036 Defaults: start with level=010, each done 3 cycles after its req rises, match=1 for every round -> gen_req rises 1 cycle after start, seq_len=8, final round_count=10, score=10, game_over=1.
REQ-037 NUM_ROUNDS=3, match pattern 1,0,1 -> score=2, round_count=3; GAP observed as exactly 4 cycles with all reqs low.
REQ-038 TIMEOUT_CYCLES=20, no inp_done -> inp_req high for exactly 20 cycles, timeout_flag=1, round scored 0; a second case with inp_done on cycle 20 -> round counted as a win.
REQ-039 start with level=011, then level=000 -> level_err pulses once per start, state stays IDLE, busy=0.
REQ-040 abort asserted during SHOW of round 5, with start in the same cycle -> IDLE next cycle, all outputs at reset values; a later rst=0 pulse during INPUT -> same reset values.
REQ-041 show_done and inp_done pulsed during GEN -> both ignored; only gen_done advances the state.
